// File: rtl/hex_anim_pkg.sv
// Shared segment patterns and FSM state encoding for the circling-segment animation.
package hex_anim_pkg;

    // Active-low patterns: a lit upper or lower square on one digit.
    localparam logic [7:0] SEG_TOP = 8'b10011100;
    localparam logic [7:0] SEG_BOT = 8'b10100011;
    localparam logic [7:0] SEG_OFF = 8'b11111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } anim_state_e;

endpackage

// File: rtl/step_tick_gen.sv
// Step-period prescaler: counts enabled cycles and pulses tick on the terminal count.
module step_tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] term;

    // ">=" rather than "==" so a shortened period mid-count fires on the next cycle.
    always_comb begin
        term  = (period == '0) ? '0 : period - DIV_W'(1);
        tick  = en && (cnt_q >= term);
        cnt_d = cnt_q;
        if (clr)       cnt_d = '0;
        else if (tick) cnt_d = '0;
        else if (en)   cnt_d = cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hex_circle_anim.sv
// Racetrack animation across N_DIG seven-segment digits: upper circles walk left,
// lower circles walk back, with start/stop/pause control and a programmable step period.
module hex_circle_anim
    import hex_anim_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int DIV_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               dir,
    input  logic [DIV_W-1:0]   period,
    output logic [8*N_DIG-1:0] hex_out,
    output logic               busy,
    output logic               step_pulse
);

    localparam int S_W = (2 * N_DIG > 1) ? $clog2(2 * N_DIG) : 1;
    localparam logic [S_W-1:0] S_LAST = S_W'(2 * N_DIG - 1);

    anim_state_e        state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [8*N_DIG-1:0] hex_q, hex_d;
    logic               step_pulse_q, step_pulse_d;
    logic               tick_en, tick_clr, tick;

    function automatic logic [8*N_DIG-1:0] frame_of(input logic [S_W-1:0] s);
        logic [8*N_DIG-1:0] f;
        f = {N_DIG{SEG_OFF}};
        for (int k = 0; k < N_DIG; k++) begin
            if (int'(s) == k)                  f[8*k +: 8] = SEG_TOP;
            else if (int'(s) == 2*N_DIG-1-k)   f[8*k +: 8] = SEG_BOT;
        end
        return f;
    endfunction

    function automatic logic [S_W-1:0] next_s(input logic [S_W-1:0] s, input logic rev);
        if (rev) return (s == '0)     ? S_LAST : s - S_W'(1);
        else     return (s == S_LAST) ? '0     : s + S_W'(1);
    endfunction

    // Prescaler only runs in RUN with no pending pause or stop, so PAUSE holds the count.
    assign tick_en  = (state_q == ST_RUN) && !pause && !stop;
    assign tick_clr = (state_q == ST_IDLE);

    step_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (tick_en),
        .clr    (tick_clr),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        hex_d        = hex_q;
        step_pulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                hex_d = {N_DIG{SEG_OFF}};
                if (start && !stop) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    hex_d   = frame_of('0);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    hex_d   = {N_DIG{SEG_OFF}};
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    s_d          = next_s(s_q, dir);
                    hex_d        = frame_of(s_d);
                    step_pulse_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    hex_d   = {N_DIG{SEG_OFF}};
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                hex_d   = {N_DIG{SEG_OFF}};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            hex_q        <= {N_DIG{SEG_OFF}};
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            hex_q        <= hex_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign hex_out    = hex_q;
    assign step_pulse = step_pulse_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hex_circle_anim.sv
// Directed bench for hex_circle_anim (N_DIG=4) with hand-computed racetrack frames.
module tb_hex_circle_anim;

    logic        clk = 1'b0;
    logic        rst, start, stop, pause, dir;
    logic [23:0] period;
    logic [31:0] hex_out;
    logic        busy, step_pulse;

    int vecs = 0;
    int errs = 0;

    hex_circle_anim #(.N_DIG(4), .DIV_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .dir        (dir),
        .period     (period),
        .hex_out    (hex_out),
        .busy       (busy),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_frame(input int s);
        case (s)
            0: return 32'hFFFF_FF9C;
            1: return 32'hFFFF_9CFF;
            2: return 32'hFF9C_FFFF;
            3: return 32'h9CFF_FFFF;
            4: return 32'hA3FF_FFFF;
            5: return 32'hFFA3_FFFF;
            6: return 32'hFFFF_A3FF;
            7: return 32'hFFFF_FFA3;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0; period = 24'd3;
        cyc(); cyc();
        chk("rst_hex", hex_out, 32'hFFFF_FFFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulse", {31'd0, step_pulse}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("idle_hex", hex_out, 32'hFFFF_FFFF);

        // Forward walk with period 3, including wrap back to digit 0.
        start = 1'b1; cyc(); start = 1'b0;
        chk("fwd_busy", {31'd0, busy}, 32'd1);
        chk("fwd_first", hex_out, exp_frame(0));
        chk("fwd_first_pulse", {31'd0, step_pulse}, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            cyc(); chk("fwd_gap1", {31'd0, step_pulse}, 32'd0);
            cyc(); chk("fwd_gap2", {31'd0, step_pulse}, 32'd0);
            cyc(); chk("fwd_pulse", {31'd0, step_pulse}, 32'd1);
            chk("fwd_frame", hex_out, exp_frame(i % 8));
        end

        // start while running is ignored; count now 1 of 3 at s=1.
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_ign", hex_out, exp_frame(1));
        chk("start_ign_pulse", {31'd0, step_pulse}, 32'd0);

        // Pause for 10 cycles, then finish the remaining count.
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("pause_pulse", {31'd0, step_pulse}, 32'd0);
            chk("pause_hex", hex_out, exp_frame(1));
            chk("pause_busy", {31'd0, busy}, 32'd1);
        end
        pause = 1'b0;
        cyc(); chk("resume_a", {31'd0, step_pulse}, 32'd0);
        cyc(); chk("resume_b", {31'd0, step_pulse}, 32'd0);
        cyc(); chk("resume_step", {31'd0, step_pulse}, 32'd1);
        chk("resume_frame", hex_out, exp_frame(2));

        // start and stop together in RUN: stop wins.
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("stop_hex", hex_out, 32'hFFFF_FFFF);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_pulse", {31'd0, step_pulse}, 32'd0);

        // start with pause in IDLE: RUN first, PAUSE next, then stop from PAUSE.
        start = 1'b1; pause = 1'b1; cyc(); start = 1'b0;
        chk("sp_run_hex", hex_out, exp_frame(0));
        chk("sp_busy", {31'd0, busy}, 32'd1);
        cyc(); cyc();
        chk("sp_hold", hex_out, exp_frame(0));
        chk("sp_pulse", {31'd0, step_pulse}, 32'd0);
        stop = 1'b1; cyc(); stop = 1'b0; pause = 1'b0;
        chk("pstop_busy", {31'd0, busy}, 32'd0);
        chk("pstop_hex", hex_out, 32'hFFFF_FFFF);

        // period 0 behaves as 1, reverse direction: 0 -> 7 -> 6 -> 5.
        period = 24'd0; dir = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        chk("rev_first", hex_out, exp_frame(0));
        cyc(); chk("rev_s7", hex_out, exp_frame(7));
        chk("rev_pulse", {31'd0, step_pulse}, 32'd1);
        cyc(); chk("rev_s6", hex_out, exp_frame(6));
        cyc(); chk("rev_s5", hex_out, exp_frame(5));
        chk("rev_pulse5", {31'd0, step_pulse}, 32'd1);

        // Asynchronous reset between clock edges at s=5.
        #2 rst = 1'b1;
        #1;
        chk("arst_hex", hex_out, 32'hFFFF_FFFF);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_pulse", {31'd0, step_pulse}, 32'd0);
        #2 rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("post_rst_hex", hex_out, 32'hFFFF_FFFF);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Period shortened from 10 to 2 while the count sits at 7.
        period = 24'd10; dir = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("p10_nostep", {31'd0, step_pulse}, 32'd0);
        end
        period = 24'd2;
        cyc(); chk("p2_imm", {31'd0, step_pulse}, 32'd1);
        chk("p2_imm_frame", hex_out, exp_frame(1));
        cyc(); chk("p2_gap", {31'd0, step_pulse}, 32'd0);
        cyc(); chk("p2_step2", {31'd0, step_pulse}, 32'd1);
        chk("p2_frame2", hex_out, exp_frame(2));
        cyc(); chk("p2_gap2", {31'd0, step_pulse}, 32'd0);
        cyc(); chk("p2_step3", {31'd0, step_pulse}, 32'd1);
        chk("p2_frame3", hex_out, exp_frame(3));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
